// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between fetch and data ports; 3 cycles/instruction, +1 per data access and per wait state.
// The bus stalls the sequencer: requests are held until bus_ack, and a stuck bus latches err after TIMEOUT_CYCLES waits.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_ren,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        cpu_step,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, IFETCH, DECODE, DWAIT, COMMIT, ERROR} state_t;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;
  logic [31:0] bus_addr_q;
  logic        addr_live;
  logic        ld_fetch, ld_refetch, ld_data, ld_inst, ld_din;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    ld_fetch     = 1'b0;
    ld_refetch   = 1'b0;
    ld_data      = 1'b0;
    ld_inst      = 1'b0;
    ld_din       = 1'b0;
    case (state)
      IDLE: begin
        if (inst_ren) begin
          state_nxt    = IFETCH;
          ld_fetch     = 1'b1;
          wait_cnt_nxt = '0;
        end
      end
      IFETCH, DWAIT: begin
        if (bus_ack) begin
          state_nxt = (state == IFETCH) ? DECODE : COMMIT;
          ld_inst   = (state == IFETCH);
          ld_din    = (state == DWAIT) && !bus_we;
        end else begin
          wait_cnt_nxt = wait_cnt + 16'd1;
          if (TIMEOUT_LIM != 16'd0 && wait_cnt_nxt == TIMEOUT_LIM) state_nxt = ERROR;
        end
      end
      DECODE: begin
        if (mem_ren || mem_wen) begin
          state_nxt    = DWAIT;
          ld_data      = 1'b1;
          wait_cnt_nxt = '0;
        end else begin
          state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        if (inst_ren) begin
          state_nxt    = IFETCH;
          ld_refetch   = 1'b1;
          wait_cnt_nxt = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      ERROR:   state_nxt = ERROR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt   <= '0;
      bus_addr_q <= '0;
      addr_live  <= 1'b0;
      bus_we     <= 1'b0;
      bus_wdata  <= '0;
      inst_data  <= '0;
      mem_din    <= '0;
    end else begin
      wait_cnt  <= wait_cnt_nxt;
      addr_live <= ld_refetch;
      if (ld_fetch) begin
        bus_addr_q <= inst_addr;
        bus_we     <= 1'b0;
      end
      if (ld_refetch) bus_we <= 1'b0;
      // The PC only settles after COMMIT's edge, so capture it during the first fetch cycle.
      if (addr_live) bus_addr_q <= inst_addr;
      if (ld_data) begin
        bus_addr_q <= mem_addr;
        bus_we     <= mem_wen;
        bus_wdata  <= mem_dout;
      end
      if (ld_inst) inst_data <= bus_rdata;
      if (ld_din)  mem_din   <= bus_rdata;
    end
  end

  // Request is a pure function of the state register, so it drops whenever the FSM leaves a bus state.
  assign bus_req  = (state == IFETCH) || (state == DWAIT);
  assign bus_addr = addr_live ? inst_addr : bus_addr_q;
  assign cpu_step = (state == COMMIT);
  assign err      = (state == ERROR);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: drives the arbiter as a datapath plus a bus, checks every output against hand-computed values.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst, inst_ren, mem_ren, mem_wen, bus_ack;
  logic [31:0] inst_addr, mem_addr, mem_dout, bus_rdata;
  logic [31:0] inst_data, mem_din, bus_addr, bus_wdata;
  logic        cpu_step, bus_req, bus_we, err;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] pc       = 32'h0;
  logic        step_seen = 1'b0;

  mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .mem_din(mem_din), .cpu_step(cpu_step),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One clock; the datapath PC advances at the edge closing a cpu_step cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (step_seen) begin
      pc        = pc + 32'd4;
      inst_addr = pc;
    end
    #1;
    step_seen = cpu_step;
  endtask

  initial begin
    rst = 1'b1; inst_ren = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    inst_addr = 32'h0; mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = 32'h0; mem_dout = 32'h0;

    // Reset held two cycles with fetch request and ack asserted
    cyc(); cyc();
    check("rst_req",   bus_req,   0);
    check("rst_step",  cpu_step,  0);
    check("rst_err",   err,       0);
    check("rst_we",    bus_we,    0);
    check("rst_addr",  bus_addr,  0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_inst",  inst_data, 0);
    check("rst_din",   mem_din,   0);
    rst = 1'b0; bus_ack = 1'b0;
    cyc();

    // ALU-only stream, zero-wait bus: step every 3rd cycle, fetches at 0,4,8
    for (int c = 0; c < 9; c++) begin
      check("alu_step", cpu_step, (c % 3 == 2));
      check("alu_req",  bus_req,  (c % 3 == 0));
      if (c % 3 == 0) begin
        check("alu_addr", bus_addr, 32'(4 * (c / 3)));
        check("alu_we",   bus_we,   0);
      end
      if (c % 3 == 1) check("alu_inst", inst_data, 32'h00221820);
      bus_ack   = (c % 3 == 0);
      bus_rdata = 32'h00221820;
      cyc();
    end

    // Load at PC 12, two wait states, spurious acks in DECODE and COMMIT
    check("ld_fetch_addr", bus_addr, 32'hC);
    check("ld_fetch_req",  bus_req,  1);
    bus_ack = 1'b1; bus_rdata = 32'h8C010100;
    cyc();
    check("ld_dec_inst", inst_data, 32'h8C010100);
    check("ld_dec_req",  bus_req,   0);
    mem_ren = 1'b1; mem_addr = 32'h100;
    bus_ack = 1'b1; bus_rdata = 32'hBAD0BAD0;
    cyc();
    check("ld_dw_req",   bus_req,   1);
    check("ld_dw_addr",  bus_addr,  32'h100);
    check("ld_dw_we",    bus_we,    0);
    check("spur_dec_inst", inst_data, 32'h8C010100);
    check("spur_dec_din",  mem_din,   0);
    bus_ack = 1'b0;
    cyc();
    check("ld_wait2_step", cpu_step, 0);
    cyc();
    check("ld_wait3_req", bus_req, 1);
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    cyc();
    check("ld_commit_step", cpu_step, 1);
    check("ld_commit_din",  mem_din,  32'hDEADBEEF);
    check("ld_commit_req",  bus_req,  0);
    bus_ack = 1'b1; bus_rdata = 32'h0BADF00D;
    cyc();
    check("spur_com_din",  mem_din,   32'hDEADBEEF);
    check("spur_com_inst", inst_data, 32'h8C010100);
    check("st_fetch_addr", bus_addr,  32'h10);
    check("st_fetch_step", cpu_step,  0);
    mem_ren = 1'b0;

    // Store at PC 16
    bus_ack = 1'b1; bus_rdata = 32'hAC020200;
    cyc();
    mem_wen = 1'b1; mem_addr = 32'h200; mem_dout = 32'h12345678; bus_ack = 1'b0;
    cyc();
    check("st_we",    bus_we,    1);
    check("st_wdata", bus_wdata, 32'h12345678);
    check("st_addr",  bus_addr,  32'h200);
    check("st_req",   bus_req,   1);
    bus_ack = 1'b1; bus_rdata = 32'h55555555;
    cyc();
    check("st_step", cpu_step, 1);
    check("st_din",  mem_din,  32'hDEADBEEF);
    mem_wen = 1'b0; bus_ack = 1'b0;
    cyc();

    // Read and write together at PC 20: handled as a write
    check("rw_fetch_addr", bus_addr, 32'h14);
    bus_ack = 1'b1; bus_rdata = 32'hAC030300;
    cyc();
    mem_ren = 1'b1; mem_wen = 1'b1; mem_addr = 32'h300; mem_dout = 32'hCAFEF00D; bus_ack = 1'b0;
    cyc();
    check("rw_we",    bus_we,    1);
    check("rw_wdata", bus_wdata, 32'hCAFEF00D);
    check("rw_addr",  bus_addr,  32'h300);
    bus_ack = 1'b1; bus_rdata = 32'h77777777;
    cyc();
    check("rw_step", cpu_step, 1);
    check("rw_din",  mem_din,  32'hDEADBEEF);
    mem_ren = 1'b0; mem_wen = 1'b0; bus_ack = 1'b0; inst_ren = 1'b0;
    cyc();
    check("idle_req",  bus_req,  0);
    check("idle_step", cpu_step, 0);

    // Reset during DWAIT, then a late ack
    inst_ren = 1'b1;
    cyc();
    check("late_fetch_addr", bus_addr, 32'h18);
    bus_ack = 1'b1; bus_rdata = 32'h8C040400;
    cyc();
    mem_ren = 1'b1; mem_addr = 32'h400; bus_ack = 1'b0;
    cyc();
    check("late_dw_req", bus_req, 1);
    inst_ren = 1'b0; rst = 1'b1;
    cyc();
    check("late_rst_req", bus_req, 0);
    rst = 1'b0; mem_ren = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h99999999;
    cyc();
    check("late_din",  mem_din,   0);
    check("late_inst", inst_data, 0);
    check("late_step", cpu_step,  0);
    check("late_req",  bus_req,   0);

    // Timeout after 4 wait cycles with no ack
    bus_ack = 1'b0; inst_ren = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      cyc();
      check("to_wait_req", bus_req, 1);
      check("to_wait_err", err,     0);
    end
    cyc();
    check("to_err", err,     1);
    check("to_req", bus_req, 0);
    bus_ack = 1'b1; bus_rdata = 32'h11111111;
    cyc(); cyc();
    check("to_late_err",  err,       1);
    check("to_late_req",  bus_req,   0);
    check("to_late_inst", inst_data, 0);
    check("to_late_step", cpu_step,  0);
    inst_ren = 1'b0; bus_ack = 1'b0; rst = 1'b1;
    cyc();
    check("to_rst_err", err, 0);
    rst = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Multi-cycle sequencer that shares one external memory bus between the datapath's instruction-fetch port and its data port. It serialises each instruction into a fetch access followed by an optional data access. It then issues a one-cycle `cpu_step` pulse that drives the datapath's `cpu_en`, so the single-cycle datapath commits exactly one instruction per pulse. The block sits between the datapath and the unified instruction/data memory and replaces the split instruction/data memory arrangement.

## Interface

- `TIMEOUT_CYCLES`, default 255: bus wait cycles allowed before a bus error is raised; 0 disables the timeout; maximum 65535.

Ports:

- `clk`  in  1  main clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `inst_ren`  in  1  fetch request from the datapath.
- `inst_addr`  in  32  fetch address (PC).
- `inst_data`  out  32  registered fetched instruction, fed to the datapath.
- `mem_ren`  in  1  data read request.
  - Must be the *ungated* control signal `mem_ren_ctrl`, not the `cpu_en`-gated version.
- `mem_wen`  in  1  data write request, likewise ungated (`mem_wen_ctrl`).
- `mem_addr`  in  32  data address (ALU result).
- `mem_dout`  in  32  write data from the datapath.
- `mem_din`  out  32  registered read data, fed to the datapath.
- `cpu_step`  out  1  one-cycle commit pulse; drives the datapath's `cpu_en`.
- `bus_req`  out  1  bus request, registered.
- `bus_we`  out  1  bus write strobe, registered.
- `bus_addr`  out  32  bus address, registered.
- `bus_wdata`  out  32  bus write data, registered.
- `bus_rdata`  in  32  bus read data; valid only while `bus_ack`=1.
- `bus_ack`  in  1  bus completion; one cycle per access.
- `err`  out  1  sticky bus-timeout flag.

## Operation

States: IDLE, IFETCH, DECODE, DWAIT, COMMIT, ERROR.

- **IDLE**
  - `bus_req`=0.
  - If `inst_ren`=1: go to IFETCH; load `bus_addr`=`inst_addr`, `bus_we`=0, `bus_req`=1.
- **IFETCH**
  - `bus_req`, `bus_addr` and `bus_we` are held stable until `bus_ack` is sampled high.
  - On ack: `inst_data`<=`bus_rdata`, `bus_req`<=0, go to DECODE.
- **DECODE**
  - One settle cycle with `bus_req`=0, so the datapath decodes the new `inst_data`.
  - At the end of the cycle, sample `mem_ren`/`mem_wen`:
    - either set: go to DWAIT, load `bus_addr`=`mem_addr`, `bus_we`=`mem_wen`, `bus_wdata`=`mem_dout`, `bus_req`=1;
    - neither set: go to COMMIT.
  - `mem_ren` and `mem_wen` both set: treated as a write (`bus_we`=1); `mem_din` is not updated.
- **DWAIT**
  - Request held stable as in IFETCH.
  - On ack: if read, `mem_din`<=`bus_rdata`; if write, `mem_din` is unchanged. Then `bus_req`<=0, go to COMMIT.
- **COMMIT**
  - `cpu_step`=1 for exactly this cycle; the datapath updates the PC, register file and memory enables at the closing edge.
  - Next state:
    - if `inst_ren`=1: go directly to IFETCH, loading the new `inst_addr` (the PC value after the edge is sampled in IFETCH's first cycle);
    - else go to IDLE.
  - Implementation detail: the IFETCH address load happens on the cycle after COMMIT, because the PC only updates at COMMIT's closing edge.
- **Timeout**
  - A 16-bit wait counter clears on entry to IFETCH or DWAIT and increments each cycle without ack.
  - If `TIMEOUT_CYCLES`≠0 and the count reaches `TIMEOUT_CYCLES`: go to ERROR.
- **ERROR**
  - `bus_req`=0, `cpu_step`=0, `err`=1.
  - Left only via `rst`.
- **Hold rules**
  - `inst_data` changes only on a fetch ack.
  - `mem_din` changes only on a data-read ack.
  - Both are stable through DECODE and COMMIT.
- **Spurious acks**
  - `bus_ack` in IDLE, DECODE, COMMIT or ERROR is ignored; no register changes.

## Timing

- **Reset values**
  - State IDLE.
  - `bus_req`, `bus_we`, `cpu_step`, `err` = 0.
  - `bus_addr`, `bus_wdata`, `inst_data`, `mem_din` = 0.
  - Wait counter = 0.
- **Reset mid-operation**
  - `rst` in any state: IDLE at the next edge with `bus_req`=0.
  - An outstanding ack arriving afterwards is ignored.
- **Earliest ack**
  - `bus_ack` may be high in the first cycle `bus_req` is high (zero wait states).
- **Instruction period with zero-wait-state bus**
  - No data access: 3 cycles (IFETCH, DECODE, COMMIT).
  - With a data access: 4 cycles.
  - Each bus wait state adds 1 cycle.
- **Pulse spacing**
  - `cpu_step` is never high on two consecutive cycles.
  - `bus_req` is low for at least 1 cycle between any two accesses.

## Test plan

- **Reset:**
  - Apply `rst` for 2 cycles while `inst_ren`=1 and `bus_ack`=1 -> all outputs 0, no `cpu_step`.
  - Release `rst` -> `bus_req`=1 with `bus_addr`=`inst_addr`.
- **ALU-only stream:**
  - Zero-wait bus returns 0x00221820 at PC 0, 4, 8, no data requests -> `cpu_step` pulses exactly every 3rd cycle.
  - Bus addresses are 0x0, 0x4, 0x8; `bus_we`=0 throughout.
- **Load:**
  - Fetch returns an lw; DECODE presents `mem_ren`=1, `mem_addr`=0x100.
  - Bus ack after 2 wait states with `bus_rdata`=0xDEADBEEF -> `mem_din`=0xDEADBEEF during COMMIT; period 6 cycles.
- **Store and simultaneous request:**
  - `mem_wen`=1, `mem_addr`=0x200, `mem_dout`=0x12345678 -> `bus_we`=1, `bus_wdata`=0x12345678, `mem_din` unchanged.
  - Repeat with `mem_ren`=`mem_wen`=1 -> write performed, `mem_din` unchanged.
- **Timeout:**
  - `TIMEOUT_CYCLES`=4, `bus_ack` held 0 -> ERROR after 4 wait cycles: `err`=1, `bus_req`=0.
  - A later ack has no effect; `rst` clears `err`.
- **Spurious/late ack:**
  - Pulse `bus_ack` in DECODE and COMMIT -> `inst_data`/`mem_din` unchanged.
  - Assert `rst` during DWAIT, then ack -> IDLE, no register update, no `cpu_step`.
